// File: rtl/fsm_input_pkg.sv
// rtl/fsm_input_pkg.sv - shared types, channel map and defaults for the input conditioner
package fsm_input_pkg;

  // Per-channel debounce states
  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } deb_state_t;

  // Fixed channel map of the operator inputs
  localparam int CH_S  = 0;
  localparam int CH_T  = 1;
  localparam int CH_H  = 2;
  localparam int CH_R  = 3;
  localparam int CH_J  = 4;
  localparam int CH_B  = 5;
  localparam int CH_P0 = 6;
  localparam int CH_P1 = 7;

  // Default configuration
  localparam int         DEF_N_IN         = 8;
  localparam int         DEF_DEB_CYCLES   = 4;
  localparam logic [7:0] DEF_REPEAT_MASK  = 8'b0010_0000;
  localparam int         DEF_REPEAT_DELAY = 32;
  localparam int         DEF_REPEAT_RATE  = 8;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input channel: sync, debounce FSM, edge pulses, optional auto-repeat (FSM_INPUT_AUTO_REPEAT_EN)
module debounce_channel
  import fsm_input_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // Reject configurations the counters cannot represent
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("debounce_channel: DEB_CYCLES out of range 1..255");
  end
  if (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_RATE < 1)) begin : g_bad_rpt
    $error("debounce_channel: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic          sync1;
  logic          sync2;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic          rpt_hit;

`ifdef FSM_INPUT_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_DELAY + REPEAT_RATE);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_inc;

  assign rpt_inc = rpt_cnt + RW'(1);
  assign rpt_hit = REPEAT_EN && ((rpt_inc == RPT_FIRST) || (rpt_inc == RPT_NEXT));

  // Repeat timer: counts cycles spent holding ST_HI, folds back by one period after each repeat
  always_ff @(posedge clk) begin
    if (reset || !REPEAT_EN || state != ST_HI || !sync2) begin
      rpt_cnt <= '0;
    end else if (rpt_inc == RPT_NEXT) begin
      rpt_cnt <= RPT_FIRST;
    end else begin
      rpt_cnt <= rpt_inc;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // Two-flop synchronizer, debounce FSM, committed level and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        ST_LO: begin
          if (sync2) begin
            if (DEB_CYCLES == 1) begin
              state <= ST_HI;
              level <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= CHK_HI;
              cnt   <= CNT_ONE;
            end
          end
        end
        CHK_HI: begin
          if (!sync2) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          if (!sync2) begin
            if (DEB_CYCLES == 1) begin
              state <= ST_LO;
              level <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= CHK_LO;
              cnt   <= CNT_ONE;
            end
          end else begin
            rise <= rpt_hit;
          end
        end
        CHK_LO: begin
          if (sync2) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fsm_input_conditioner.sv
// rtl/fsm_input_conditioner.sv - operator input front end, one debounce channel per input (FSM_INPUT_AUTO_REPEAT_EN adds auto-repeat)
module fsm_input_conditioner
  import fsm_input_pkg::*;
#(
  parameter int              N_IN         = DEF_N_IN,
  parameter int              DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter logic [N_IN-1:0] REPEAT_MASK  = N_IN'(DEF_REPEAT_MASK),
  parameter int              REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int              REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level_out,
  output logic [N_IN-1:0] rise_pulse,
  output logic [N_IN-1:0] fall_pulse
);

  // Independent conditioner per channel; repeat eligibility comes from the mask
  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_EN   (REPEAT_MASK[i]),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .level(level_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

endmodule
